id_ex_stage: RTL
================

# id_ex_stage

ID/EX pipeline stage sitting directly upstream of the ALU. It captures one decoded instruction per cycle from decode and holds it under a valid/ready handshake. It resolves register operands from the MEM and WB stages and drives the ALU's `operand1_in`, `operand2_in` and `aluOp_in`, plus the destination metadata that travels alongside the result.

## Interface
- `DATA_WIDTH_POW`, 6, log2 of datapath width.
- `DATA_WIDTH`, `1 << DATA_WIDTH_POW`, datapath width.
- `REG_ADDR_WIDTH`, 5, register index width.

Ports:
- `clk_in`  in  1  clock; all state updates on the rising edge.
- `rst_in`  in  1  reset, synchronous, active-high.
- `idValid_in`  in  1  decode presents an instruction.
- `idReady_out`  out  1  stage accepts this cycle.
- `rs1Addr_in`, `rs2Addr_in`  in  `REG_ADDR_WIDTH`  source indices.
- `rs1Data_in`, `rs2Data_in`  in  `DATA_WIDTH`  register-file read data.
- `imm_in`  in  `DATA_WIDTH`  sign-extended immediate.
- `aluSrc_in`  in  1  1 = operand2 from the immediate.
- `aluOp_in`  in  `aluOperation_t`  operation.
- `rdAddr_in`  in  `REG_ADDR_WIDTH`  destination index.
- `regWrite_in`  in  1  instruction writes rd.
- `flush_in`  in  1  kill the held and the incoming instruction.
- `exReady_in`  in  1  EX consumer accepts the held instruction.
- `memRegWrite_in`, `memRdAddr_in`, `memResult_in`  in  1/`REG_ADDR_WIDTH`/`DATA_WIDTH`  EX/MEM producer.
- `wbRegWrite_in`, `wbRdAddr_in`, `wbResult_in`  in  1/`REG_ADDR_WIDTH`/`DATA_WIDTH`  MEM/WB producer.
- `exValid_out`  out  1  held entry is valid.
- `operand1_out`, `operand2_out`  out  `DATA_WIDTH`  to the ALU.
- `aluOp_out`  out  `aluOperation_t`  to the ALU.
- `rdAddr_out`  out  `REG_ADDR_WIDTH`; `regWrite_out`  out  1.
- `hazardStall_out`  out  1  RAW interlock active.

## Operation
- Single-entry register. `idReady_out = (!exValid_out || exReady_in) && !flush_in && !hazardStall_out`.
- Capture occurs when `idValid_in && idReady_out`. All ID fields are stored, including rs indices, and `exValid_out` is set.
- Release occurs when `exValid_out && exReady_in` with no capture in the same cycle. `exValid_out` clears.
- Capture and release in the same cycle: the new entry replaces the old one, giving a throughput of 1 per cycle.
- `flush_in` takes priority over everything. Next cycle `exValid_out = 0` and no capture occurs.
- `regWrite_out = regWrite_q && exValid_out`. A bubble never writes.
- Forward match for rsN: `regWrite && rdAddr == rsN && rsN != 0`. x0 is never forwarded.
- Operand priority: MEM match, then WB match, then the stored value.
- `operand2_out` equals the stored immediate when `aluSrc` is 1; the immediate is never forwarded.
- Operand refresh: while an entry is held (`exValid_out && !exReady_in`), a WB match overwrites the stored rsN data. The value therefore survives WB retiring during a stall.

## Timing
- On reset, outputs are zero next edge: `exValid_out = 0`, operands 0, `aluOp_out = OP_ADD`, `rdAddr_out = 0`, `regWrite_out = 0`, `hazardStall_out = 0`.
- Reset mid-stall discards the held entry.
- Latency is 1 cycle from ID handshake to `exValid_out`.
- Forward muxes are combinational from the `mem*`/`wb*` inputs to the operand outputs in the same cycle.
- `hazardStall_out` is combinational from the ID inputs and the held and MEM state.
- Held outputs are stable while `exValid_out && !exReady_in`, except when a forward source changes.

## Configuration
- `ID_EX_FORWARD_EN` defined: MEM/WB forwarding and operand refresh are present. `hazardStall_out` is tied to 0.
- `ID_EX_FORWARD_EN` undefined: no forwarding; operands come only from stored data. `hazardStall_out` asserts when `idValid_in` and any non-zero rs1/rs2 index matches one of:
  - held rd, with `regWrite_out` set;
  - MEM rd, with `memRegWrite_in` set;
  - WB rd, with `wbRegWrite_in` set.
- In that case `idReady_out` is low.
- Load-use interlock belongs to decode in both builds.

## Test plan
- Reset, then `ADD` with rs1=5, rs2=7 (data 3, 4) and `exReady_in` = 1 → next cycle `exValid_out` = 1, operands 3/4, `aluOp_out` = `OP_ADD`.
- Back-to-back accept: 4 instructions on consecutive cycles with `exReady_in` = 1 → 4 consecutive valid outputs, `idReady_out` never low.
- Forwarding: held rs1=5, MEM rd=5 with result 0xAA and WB rd=5 with result 0xBB → `operand1_out` = 0xAA. With MEM rd=0 and rs1=0, stored data is used.
- Stall refresh: `exReady_in` = 0 and WB writes rd=6 = 0x1234 while rs2=6 is held; then `exReady_in` = 1 with WB idle → `operand2_out` = 0x1234.
- Flush while held with `idValid_in` = 1 → next cycle `exValid_out` = 0 and `regWrite_out` = 0; the incoming instruction is not captured.
- Without `ID_EX_FORWARD_EN`: held rd=9 with write, incoming rs1=9 → `hazardStall_out` = 1 and `idReady_out` = 0. With rs1=0 → no stall.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: single-entry valid/ready holding stage that feeds the ALU.
// Build macro ID_EX_FORWARD_EN selects MEM/WB forwarding with operand refresh; without it a RAW interlock stalls decode.
package id_ex_pkg;
    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_SLT  = 4'd8,
        OP_SLTU = 4'd9
    } aluOperation_t;
endpackage

module id_ex_stage #(
    parameter int DATA_WIDTH_POW = 6,
    parameter int DATA_WIDTH     = 32'd1 << DATA_WIDTH_POW,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          idValid_in,
    output logic                          idReady_out,
    input  logic [REG_ADDR_WIDTH-1:0]     rs1Addr_in,
    input  logic [REG_ADDR_WIDTH-1:0]     rs2Addr_in,
    input  logic [DATA_WIDTH-1:0]         rs1Data_in,
    input  logic [DATA_WIDTH-1:0]         rs2Data_in,
    input  logic [DATA_WIDTH-1:0]         imm_in,
    input  logic                          aluSrc_in,
    input  id_ex_pkg::aluOperation_t      aluOp_in,
    input  logic [REG_ADDR_WIDTH-1:0]     rdAddr_in,
    input  logic                          regWrite_in,
    input  logic                          flush_in,
    input  logic                          exReady_in,
    input  logic                          memRegWrite_in,
    input  logic [REG_ADDR_WIDTH-1:0]     memRdAddr_in,
    input  logic [DATA_WIDTH-1:0]         memResult_in,
    input  logic                          wbRegWrite_in,
    input  logic [REG_ADDR_WIDTH-1:0]     wbRdAddr_in,
    input  logic [DATA_WIDTH-1:0]         wbResult_in,
    output logic                          exValid_out,
    output logic [DATA_WIDTH-1:0]         operand1_out,
    output logic [DATA_WIDTH-1:0]         operand2_out,
    output id_ex_pkg::aluOperation_t      aluOp_out,
    output logic [REG_ADDR_WIDTH-1:0]     rdAddr_out,
    output logic                          regWrite_out,
    output logic                          hazardStall_out
);
    import id_ex_pkg::*;

    logic                      valid_r;
    logic [REG_ADDR_WIDTH-1:0] rs1_addr_r;
    logic [REG_ADDR_WIDTH-1:0] rs2_addr_r;
    logic [DATA_WIDTH-1:0]     rs1_data_r;
    logic [DATA_WIDTH-1:0]     rs2_data_r;
    logic [DATA_WIDTH-1:0]     imm_r;
    logic                      alu_src_r;
    aluOperation_t             alu_op_r;
    logic [REG_ADDR_WIDTH-1:0] rd_addr_r;
    logic                      reg_write_r;
    logic                      hazard_s;
    logic                      capture_s;

    // A producer matches a source only when it writes that register and it is not x0.
    function automatic logic fwd_hit(input logic                      we,
                                     input logic [REG_ADDR_WIDTH-1:0] rd,
                                     input logic [REG_ADDR_WIDTH-1:0] rs);
        return we && (rd == rs) && (rs != {REG_ADDR_WIDTH{1'b0}});
    endfunction

    assign idReady_out     = (!valid_r || exReady_in) && !flush_in && !hazard_s;
    assign capture_s       = idValid_in && idReady_out;
    assign hazardStall_out = hazard_s;
    assign exValid_out     = valid_r;
    assign aluOp_out       = alu_op_r;
    assign rdAddr_out      = rd_addr_r;
    assign regWrite_out    = reg_write_r && valid_r;

`ifdef ID_EX_FORWARD_EN
    logic [DATA_WIDTH-1:0] rs2_fwd_s;

    assign hazard_s = 1'b0;

    // Operand muxes: MEM result beats WB result beats the stored register data.
    always_comb begin
        operand1_out = rs1_data_r;
        rs2_fwd_s    = rs2_data_r;
        if (fwd_hit(memRegWrite_in, memRdAddr_in, rs1_addr_r)) begin
            operand1_out = memResult_in;
        end else if (fwd_hit(wbRegWrite_in, wbRdAddr_in, rs1_addr_r)) begin
            operand1_out = wbResult_in;
        end else begin
            operand1_out = rs1_data_r;
        end
        if (fwd_hit(memRegWrite_in, memRdAddr_in, rs2_addr_r)) begin
            rs2_fwd_s = memResult_in;
        end else if (fwd_hit(wbRegWrite_in, wbRdAddr_in, rs2_addr_r)) begin
            rs2_fwd_s = wbResult_in;
        end else begin
            rs2_fwd_s = rs2_data_r;
        end
        operand2_out = alu_src_r ? imm_r : rs2_fwd_s;
    end
`else
    logic rs1_busy_s;
    logic rs2_busy_s;
    logic unused_s;

    assign rs1_busy_s = fwd_hit(regWrite_out, rd_addr_r, rs1Addr_in)
                      || fwd_hit(memRegWrite_in, memRdAddr_in, rs1Addr_in)
                      || fwd_hit(wbRegWrite_in, wbRdAddr_in, rs1Addr_in);
    assign rs2_busy_s = fwd_hit(regWrite_out, rd_addr_r, rs2Addr_in)
                      || fwd_hit(memRegWrite_in, memRdAddr_in, rs2Addr_in)
                      || fwd_hit(wbRegWrite_in, wbRdAddr_in, rs2Addr_in);
    assign hazard_s   = idValid_in && (rs1_busy_s || rs2_busy_s);

    // Results and stored source indices only matter when forwarding is built in.
    assign unused_s     = ^{memResult_in, wbResult_in, rs1_addr_r, rs2_addr_r};
    assign operand1_out = rs1_data_r;
    assign operand2_out = alu_src_r ? imm_r : rs2_data_r;
`endif

    // Entry register: reset, flush, capture, release, then WB refresh while stalled.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid_r     <= 1'b0;
            rs1_addr_r  <= {REG_ADDR_WIDTH{1'b0}};
            rs2_addr_r  <= {REG_ADDR_WIDTH{1'b0}};
            rs1_data_r  <= {DATA_WIDTH{1'b0}};
            rs2_data_r  <= {DATA_WIDTH{1'b0}};
            imm_r       <= {DATA_WIDTH{1'b0}};
            alu_src_r   <= 1'b0;
            alu_op_r    <= OP_ADD;
            rd_addr_r   <= {REG_ADDR_WIDTH{1'b0}};
            reg_write_r <= 1'b0;
        end else if (flush_in) begin
            valid_r <= 1'b0;
        end else if (capture_s) begin
            valid_r     <= 1'b1;
            rs1_addr_r  <= rs1Addr_in;
            rs2_addr_r  <= rs2Addr_in;
            rs1_data_r  <= rs1Data_in;
            rs2_data_r  <= rs2Data_in;
            imm_r       <= imm_in;
            alu_src_r   <= aluSrc_in;
            alu_op_r    <= aluOp_in;
            rd_addr_r   <= rdAddr_in;
            reg_write_r <= regWrite_in;
        end else if (valid_r && exReady_in) begin
            valid_r <= 1'b0;
`ifdef ID_EX_FORWARD_EN
        end else if (valid_r) begin
            // Latch WB results so they survive the producer retiring mid-stall.
            if (fwd_hit(wbRegWrite_in, wbRdAddr_in, rs1_addr_r)) begin
                rs1_data_r <= wbResult_in;
            end
            if (fwd_hit(wbRegWrite_in, wbRdAddr_in, rs2_addr_r)) begin
                rs2_data_r <= wbResult_in;
            end
`endif
        end
    end

endmodule
